// File: rtl/exu_pkg.sv
// rtl/exu_pkg.sv - shared widths and ALU opcodes for the execute-stage datapath slice
package exu_pkg;

    localparam int XLEN    = 64;
    localparam int NREG_AW = 5;
    localparam int NREG    = 1 << NREG_AW;

    localparam logic [1:0] ALUOP_PASS = 2'b00;
    localparam logic [1:0] ALUOP_ADD  = 2'b01;
    localparam logic [1:0] ALUOP_SLTU = 2'b10;
    localparam logic [1:0] ALUOP_RSVD = 2'b11;

endpackage

// File: rtl/exu_rf_alu_if.sv
// rtl/exu_rf_alu_if.sv - decoder-to-execute bundle: register ports, write port, ALU operands
interface exu_rf_alu_if;
    import exu_pkg::*;

    logic [NREG_AW-1:0] raddr1;
    logic [XLEN-1:0]    rdata1;
    logic [NREG_AW-1:0] raddr2;
    logic [XLEN-1:0]    rdata2;
    logic               we;
    logic [NREG_AW-1:0] waddr;
    logic [XLEN-1:0]    wdata;
    logic [XLEN-1:0]    alu_src1;
    logic [XLEN-1:0]    alu_src2;
    logic [1:0]         aluop;
    logic [XLEN-1:0]    alu_result;

    // master is the decoder side, slave is the execute slice
    modport master (
        output raddr1, raddr2, we, waddr, wdata, alu_src1, alu_src2, aluop,
        input  rdata1, rdata2, alu_result
    );

    modport slave (
        input  raddr1, raddr2, we, waddr, wdata, alu_src1, alu_src2, aluop,
        output rdata1, rdata2, alu_result
    );

endinterface

// File: rtl/exu_alu.sv
// rtl/exu_alu.sv - combinational XLEN ALU: pass, add, unsigned set-less-than
module exu_alu
    import exu_pkg::*;
(
    input  logic [XLEN-1:0] alu_src1,
    input  logic [XLEN-1:0] alu_src2,
    input  logic [1:0]      aluop,
    output logic [XLEN-1:0] alu_result
);

    always_comb begin
        alu_result = '0;
        case (aluop)
            ALUOP_PASS: alu_result = alu_src2;
            ALUOP_ADD:  alu_result = alu_src1 + alu_src2;
            ALUOP_SLTU: alu_result = {{(XLEN-1){1'b0}}, (alu_src1 < alu_src2)};
            ALUOP_RSVD: alu_result = '0;
            default:    alu_result = '0;
        endcase
    end

endmodule

// File: rtl/exu_regfile.sv
// rtl/exu_regfile.sv - 32 x XLEN register file, two combinational read ports, one write port
module exu_regfile
    import exu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NREG_AW-1:0] raddr1,
    output logic [XLEN-1:0]    rdata1,
    input  logic [NREG_AW-1:0] raddr2,
    output logic [XLEN-1:0]    rdata2,
    input  logic               we,
    input  logic [NREG_AW-1:0] waddr,
    input  logic [XLEN-1:0]    wdata
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // No bypass; reads are masked to zero while reset is held and for x0
    assign rdata1 = (rst && (raddr1 != '0)) ? regs[raddr1] : '0;
    assign rdata2 = (rst && (raddr2 != '0)) ? regs[raddr2] : '0;

endmodule

// File: rtl/exu_rf_alu.sv
// rtl/exu_rf_alu.sv - execute-stage slice: wires the register file and ALU to the decoder bundle
module exu_rf_alu
    import exu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    exu_rf_alu_if.slave  bus
);

    exu_regfile u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (bus.raddr1),
        .rdata1 (bus.rdata1),
        .raddr2 (bus.raddr2),
        .rdata2 (bus.rdata2),
        .we     (bus.we),
        .waddr  (bus.waddr),
        .wdata  (bus.wdata)
    );

    exu_alu u_alu (
        .alu_src1   (bus.alu_src1),
        .alu_src2   (bus.alu_src2),
        .aluop      (bus.aluop),
        .alu_result (bus.alu_result)
    );

endmodule

// File: tb/tb_exu_rf_alu.sv
// tb/tb_exu_rf_alu.sv - directed self-checking bench for exu_rf_alu
module tb_exu_rf_alu;
    import exu_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    exu_rf_alu_if bus ();

    exu_rf_alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst          = 1'b0;
        bus.raddr1   = 5'd0;
        bus.raddr2   = 5'd0;
        bus.we       = 1'b0;
        bus.waddr    = 5'd0;
        bus.wdata    = 64'h0;
        bus.alu_src1 = 64'h0;
        bus.alu_src2 = 64'h0;
        bus.aluop    = ALUOP_PASS;

        // Reads are zero while reset is held, even before the first edge
        #2;
        bus.raddr1 = 5'd9;
        bus.raddr2 = 5'd17;
        #1;
        check("rst_held_rd1", bus.rdata1, 64'h0);
        check("rst_held_rd2", bus.rdata2, 64'h0);

        tick();
        tick();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            bus.raddr1 = 5'(i);
            bus.raddr2 = 5'(31 - i);
            #1;
            check($sformatf("reset_rd1_x%0d", i), bus.rdata1, 64'h0);
            check($sformatf("reset_rd2_x%0d", 31 - i), bus.rdata2, 64'h0);
        end

        // Write x5; same-cycle read of waddr returns old value on both ports
        bus.we     = 1'b1;
        bus.waddr  = 5'd5;
        bus.wdata  = 64'hDEAD_BEEF_0123_4567;
        bus.raddr1 = 5'd5;
        bus.raddr2 = 5'd5;
        #1;
        check("x5_same_cycle_rd1", bus.rdata1, 64'h0);
        check("x5_same_cycle_rd2", bus.rdata2, 64'h0);
        tick();
        bus.we = 1'b0;
        #1;
        check("x5_after_rd1", bus.rdata1, 64'hDEAD_BEEF_0123_4567);
        check("x5_after_rd2", bus.rdata2, 64'hDEAD_BEEF_0123_4567);

        bus.we    = 1'b1;
        bus.waddr = 5'd31;
        bus.wdata = 64'h1;
        tick();
        bus.we     = 1'b0;
        bus.raddr1 = 5'd31;
        bus.raddr2 = 5'd31;
        #1;
        check("x31_rd1", bus.rdata1, 64'h1);
        check("x31_rd2", bus.rdata2, 64'h1);

        // x0 ignores writes
        bus.we    = 1'b1;
        bus.waddr = 5'd0;
        bus.wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        bus.we     = 1'b0;
        bus.raddr1 = 5'd0;
        bus.raddr2 = 5'd0;
        #1;
        check("x0_rd1", bus.rdata1, 64'h0);
        check("x0_rd2", bus.rdata2, 64'h0);

        // x7 loaded, then we=0 must leave it alone
        bus.we    = 1'b1;
        bus.waddr = 5'd7;
        bus.wdata = 64'h77;
        tick();
        bus.we    = 1'b0;
        bus.wdata = 64'hFF;
        tick();
        bus.raddr1 = 5'd7;
        #1;
        check("x7_we0_unchanged", bus.rdata1, 64'h77);

        // Overwrite x31 so x5, x7 and x31 are all non-zero before reset
        bus.we    = 1'b1;
        bus.waddr = 5'd31;
        bus.wdata = 64'hA5A5_0000_0000_5A5A;
        tick();
        bus.we     = 1'b0;
        bus.raddr2 = 5'd31;
        #1;
        check("x31_overwrite", bus.rdata2, 64'hA5A5_0000_0000_5A5A);

        // Reset overrides a simultaneous write and clears loaded registers
        rst        = 1'b0;
        bus.we     = 1'b1;
        bus.waddr  = 5'd3;
        bus.wdata  = 64'h55;
        bus.raddr1 = 5'd5;
        #1;
        check("rst_mid_rd_mask", bus.rdata1, 64'h0);
        tick();
        rst    = 1'b1;
        bus.we = 1'b0;
        bus.raddr1 = 5'd3;
        bus.raddr2 = 5'd5;
        #1;
        check("rst_blocks_write_x3", bus.rdata1, 64'h0);
        check("rst_clears_x5", bus.rdata2, 64'h0);
        bus.raddr1 = 5'd7;
        bus.raddr2 = 5'd31;
        #1;
        check("rst_clears_x7", bus.rdata1, 64'h0);
        check("rst_clears_x31", bus.rdata2, 64'h0);

        // ALU
        bus.aluop    = ALUOP_ADD;
        bus.alu_src1 = 64'h8000_0000;
        bus.alu_src2 = 64'hFFFF_FFFF_FFFF_FFFC;
        #1;
        check("add_neg4", bus.alu_result, 64'h7FFF_FFFC);
        bus.alu_src1 = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.alu_src2 = 64'h1;
        #1;
        check("add_wrap", bus.alu_result, 64'h0);
        bus.alu_src1 = 64'h0000_0001_0000_0002;
        bus.alu_src2 = 64'h0000_0003_0000_0004;
        #1;
        check("add_plain", bus.alu_result, 64'h0000_0004_0000_0006);

        bus.aluop    = ALUOP_SLTU;
        bus.alu_src1 = 64'h1;
        bus.alu_src2 = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        check("sltu_lt", bus.alu_result, 64'h1);
        bus.alu_src1 = 64'h5;
        bus.alu_src2 = 64'h5;
        #1;
        check("sltu_eq", bus.alu_result, 64'h0);
        bus.alu_src1 = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.alu_src2 = 64'h1;
        #1;
        check("sltu_gt", bus.alu_result, 64'h0);

        bus.aluop    = ALUOP_PASS;
        bus.alu_src1 = 64'hFFFF_0000_FFFF_0000;
        bus.alu_src2 = 64'h0000_0000_1234_5000;
        #1;
        check("pass", bus.alu_result, 64'h0000_0000_1234_5000);

        bus.aluop = ALUOP_RSVD;
        #1;
        check("rsvd", bus.alu_result, 64'h0);

        // ALU ignores reset
        rst          = 1'b0;
        bus.aluop    = ALUOP_ADD;
        bus.alu_src1 = 64'h10;
        bus.alu_src2 = 64'h20;
        #1;
        check("add_in_reset", bus.alu_result, 64'h30);
        tick();
        rst = 1'b1;
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exu_rf_alu.md
Name: exu_rf_alu

Overview:
- Execute-stage datapath slice for the single-cycle RV64 core: a 32 x 64-bit integer register file plus a 64-bit ALU.
- The instruction decoder in the core top level drives the register addresses, write controls, ALU operands and ALU opcode.
- The core top level uses the read data for branch compare, store data and halt value.
- The core top level uses the ALU result for writeback and address generation.

Parameters:
- XLEN, 64, datapath width in bits.
- NREG, 32, number of architectural registers; address width is log2(NREG) = 5.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset (asserted when 0).
- raddr1  in  5  read port 1 register index.
- rdata1  out  64  read port 1 data.
- raddr2  in  5  read port 2 register index.
- rdata2  out  64  read port 2 data.
- we  in  1  write enable.
- waddr  in  5  write register index.
- wdata  in  64  write data.
- alu_src1  in  64  ALU operand A.
- alu_src2  in  64  ALU operand B (immediate in the current core).
- aluop  in  2  ALU operation select.
- alu_result  out  64  ALU result.

Behaviour:
Register file:
- Read ports are combinational, with zero cycles of latency: rdataN = reg[raddrN].
- Register x0 always reads 0.
- A write occurs on the rising edge of clk when rst = 1 and we = 1: reg[waddr] <= wdata.
- A write to x0 is discarded.
- No write bypass: a read of waddr in the same cycle as the write returns the old value; the new value is visible after the edge.
- Reset: when rst = 0 at a rising edge, x1..x31 clear to 0. A write requested in that same cycle is ignored.
- While reset is held, rdata1 and rdata2 read 0 for every address.
- Reset applied mid-operation clears all state on the next edge; there is no partial state.
- Both read ports may address the same register, including waddr; each returns the same value.

ALU:
- Purely combinational, no state, unaffected by reset.
- aluop = 2'b01 (ADD): alu_result = alu_src1 + alu_src2, modulo 2^64, carry discarded.
- aluop = 2'b10 (SLTU): alu_result = {63'b0, (alu_src1 < alu_src2)}, unsigned compare.
- aluop = 2'b00 (PASS): alu_result = alu_src2, used for LUI-style pass-through.
- aluop = 2'b11 (reserved): alu_result = 0.

Output reset values:
- rdata1 and rdata2 are 0 after reset, for any address.
- alu_result follows its inputs combinationally at all times.

Decomposition:
- Shared package exu_pkg holds:
  - XLEN and NREG_AW = 5.
  - ALU opcode constants ALUOP_PASS = 2'b00, ALUOP_ADD = 2'b01, ALUOP_SLTU = 2'b10, ALUOP_RSVD = 2'b11.
- Two sub-modules:
  - exu_regfile, holding the register array with its read and write logic.
  - exu_alu, combinational.
- exu_rf_alu only instantiates and wires the two sub-modules.

Test Plan:
- Reset then read: hold rst = 0 for 2 cycles, release, read all 32 registers on both ports -> every rdata = 0.
- Write/read-back: write x5 = 64'hDEAD_BEEF_0123_4567; same cycle raddr1 = 5 -> old value 0; next cycle -> 64'hDEAD_BEEF_0123_4567. Write x31 = 64'h1 and read on both ports -> 1.
- x0 immutability: we = 1, waddr = 0, wdata = 64'hFFFF_FFFF_FFFF_FFFF -> rdata1 with raddr1 = 0 stays 0. Repeat with we = 0, waddr = 7 -> x7 unchanged.
- Reset overrides write: rst = 0 with we = 1, waddr = 3, wdata = 64'h55 -> x3 = 0 afterwards. Reset after x5 is loaded -> x5 = 0.
- ALU ADD: src1 = 64'h8000_0000, src2 = 64'hFFFF_FFFF_FFFF_FFFC (-4) -> 64'h7FFF_FFFC. src1 = 64'hFFFF_FFFF_FFFF_FFFF, src2 = 1 -> 0 (wrap).
- ALU SLTU/PASS/RSVD:
  - SLTU with src1 = 1, src2 = 64'hFFFF_FFFF_FFFF_FFFF -> 1.
  - SLTU with src1 = 5, src2 = 5 -> 0.
  - PASS with src2 = 64'h0000_0000_1234_5000 -> 64'h0000_0000_1234_5000.
  - aluop = 3 -> 0.
